pong_game_ctrl: RTL and testbench

Game-sequencing controller for the pong display pipeline. Generates the per-frame refresh tick from the pixel scan position. Runs the title / play / next-ball / game-over state machine that freezes and releases the ball animation. Keeps the two-digit BCD score and the remaining-ball count that the animation and text overlays display.

---
 rtl/pong_pkg.sv | 36 +++
 rtl/pong_bcd_counter.sv | 30 +++
 rtl/pong_game_ctrl.sv | 139 +++++++++++++
 tb/tb_pong_game_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared constants and state encodings for the pong game sequencing logic.
package pong_pkg;

   localparam int unsigned MAX_X    = 640;
   localparam int unsigned MAX_Y    = 480;
   localparam int unsigned REFR_ROW = MAX_Y + 1;

   localparam int unsigned PIX_W   = 10;
   localparam int unsigned STATE_W = 2;
   localparam int unsigned DIGIT_W = 4;

   localparam logic [STATE_W-1:0] ST_NEWGAME = 2'b00;
   localparam logic [STATE_W-1:0] ST_PLAY    = 2'b01;
   localparam logic [STATE_W-1:0] ST_NEWBALL = 2'b10;
   localparam logic [STATE_W-1:0] ST_OVER    = 2'b11;

   localparam logic [1:0] TXT_TITLE = 2'b00;
   localparam logic [1:0] TXT_PLAY  = 2'b01;
   localparam logic [1:0] TXT_BALL  = 2'b10;
   localparam logic [1:0] TXT_OVER  = 2'b11;

   // Overlay shown for each game state.
   function automatic logic [1:0] text_code(input logic [STATE_W-1:0] st);
      logic [1:0] code;
      code = TXT_TITLE;
      case (st)
         ST_NEWGAME: code = TXT_TITLE;
         ST_PLAY:    code = TXT_PLAY;
         ST_NEWBALL: code = TXT_BALL;
         ST_OVER:    code = TXT_OVER;
         default:    code = TXT_TITLE;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/pong_bcd_counter.sv
// Two-digit BCD counter, 00..99 with wrap; synchronous clear beats increment.
module pong_bcd_counter
   import pong_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               clr,
   input  logic               inc,
   output logic [DIGIT_W-1:0] dig1,
   output logic [DIGIT_W-1:0] dig0
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dig1 <= '0;
         dig0 <= '0;
      end else if (clr) begin
         dig1 <= '0;
         dig0 <= '0;
      end else if (inc) begin
         if (dig0 == DIGIT_W'(9)) begin
            dig0 <= '0;
            dig1 <= (dig1 == DIGIT_W'(9)) ? '0 : dig1 + DIGIT_W'(1);
         end else begin
            dig0 <= dig0 + DIGIT_W'(1);
         end
      end
   end

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: frame tick, title/play/next-ball/over FSM, score and lives.
module pong_game_ctrl
   import pong_pkg::*;
#(
   parameter int unsigned LIVES       = 3,
   parameter int unsigned WAIT_FRAMES = 120
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [PIX_W-1:0]   pix_x,
   input  logic [PIX_W-1:0]   pix_y,
   input  logic [1:0]         btn,
   input  logic               hit,
   input  logic               miss,
   output logic               refr_tick,
   output logic               gra_still,
   output logic               ball_reload,
   output logic [DIGIT_W-1:0] dig1,
   output logic [DIGIT_W-1:0] dig0,
   output logic [1:0]         balls_left,
   output logic [1:0]         text_sel
);

   localparam int unsigned TIMER_W = $clog2(WAIT_FRAMES + 1);

   logic [STATE_W-1:0] state;
   logic [STATE_W-1:0] state_next;
   logic [TIMER_W-1:0] timer;
   logic [1:0]         btn_q;

   logic press_c;
   logic expired_c;
   logic reload_c;
   logic score_inc_c;
   logic score_clr_c;
   logic lose_ball_c;
   logic refill_c;
   logic timer_clr_c;

   assign press_c   = |(btn & ~btn_q);
   assign expired_c = (timer == TIMER_W'(WAIT_FRAMES));

   // Next-state and event decode.
   always_comb begin
      state_next  = state;
      reload_c    = 1'b0;
      score_inc_c = 1'b0;
      score_clr_c = 1'b0;
      lose_ball_c = 1'b0;
      refill_c    = 1'b0;
      case (state)
         ST_NEWGAME: begin
            if (press_c) begin
               state_next = ST_PLAY;
               reload_c   = 1'b1;
            end
         end
         ST_PLAY: begin
            if (miss) begin
               lose_ball_c = 1'b1;
               state_next  = (balls_left == 2'd1) ? ST_OVER : ST_NEWBALL;
            end else if (hit) begin
               score_inc_c = 1'b1;
            end
         end
         ST_NEWBALL: begin
            if (expired_c && press_c) begin
               state_next = ST_PLAY;
               reload_c   = 1'b1;
            end
         end
         ST_OVER: begin
            if (expired_c) begin
               state_next  = ST_NEWGAME;
               score_clr_c = 1'b1;
               refill_c    = 1'b1;
            end
         end
         default: state_next = ST_NEWGAME;
      endcase
   end

   assign timer_clr_c = (state_next != state) &&
                        ((state_next == ST_NEWBALL) || (state_next == ST_OVER));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_NEWGAME;
      end else begin
         state <= state_next;
      end
   end

   // Frame tick, button edge history and dwell timer.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         refr_tick <= 1'b0;
         btn_q     <= '0;
         timer     <= '0;
      end else begin
         refr_tick <= (pix_x == PIX_W'(0)) && (pix_y == PIX_W'(REFR_ROW));
         btn_q     <= btn;
         if (timer_clr_c) begin
            timer <= '0;
         end else if (refr_tick && !expired_c) begin
            timer <= timer + TIMER_W'(1);
         end
      end
   end

   // Outputs follow the next state so they line up with the state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         gra_still   <= 1'b1;
         ball_reload <= 1'b0;
         text_sel    <= TXT_TITLE;
         balls_left  <= 2'(LIVES);
      end else begin
         gra_still   <= (state_next != ST_PLAY);
         ball_reload <= reload_c;
         text_sel    <= text_code(state_next);
         if (refill_c) begin
            balls_left <= 2'(LIVES);
         end else if (lose_ball_c) begin
            balls_left <= balls_left - 2'd1;
         end
      end
   end

   pong_bcd_counter u_score (
      .clk   (clk),
      .reset (reset),
      .clr   (score_clr_c),
      .inc   (score_inc_c),
      .dig1  (dig1),
      .dig0  (dig0)
   );

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed self-checking bench for pong_game_ctrl with LIVES=3, WAIT_FRAMES=2.
module tb_pong_game_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [9:0] pix_x = 10'd5;
   logic [9:0] pix_y = 10'd100;
   logic [1:0] btn = 2'b00;
   logic       hit = 1'b0;
   logic       miss = 1'b0;
   logic       refr_tick;
   logic       gra_still;
   logic       ball_reload;
   logic [3:0] dig1;
   logic [3:0] dig0;
   logic [1:0] balls_left;
   logic [1:0] text_sel;

   int n_checks = 0;
   int n_errors = 0;

   pong_game_ctrl #(.LIVES(3), .WAIT_FRAMES(2)) dut (
      .clk         (clk),
      .reset       (reset),
      .pix_x       (pix_x),
      .pix_y       (pix_y),
      .btn         (btn),
      .hit         (hit),
      .miss        (miss),
      .refr_tick   (refr_tick),
      .gra_still   (gra_still),
      .ball_reload (ball_reload),
      .dig1        (dig1),
      .dig0        (dig0),
      .balls_left  (balls_left),
      .text_sel    (text_sel)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One frame tick: pixel match for one cycle, then one more cycle so the timer absorbs it.
   task automatic frame_tick();
      pix_x = 10'd0;
      pix_y = 10'd481;
      step();
      pix_x = 10'd5;
      pix_y = 10'd100;
      step();
   endtask

   task automatic press();
      btn = 2'b01;
      step();
      btn = 2'b00;
   endtask

   task automatic hits(input int n);
      hit = 1'b1;
      repeat (n) step();
      hit = 1'b0;
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_still"}, 32'(gra_still), 32'd1);
      check({tag, "_reload"}, 32'(ball_reload), 32'd0);
      check({tag, "_dig1"}, 32'(dig1), 32'd0);
      check({tag, "_dig0"}, 32'(dig0), 32'd0);
      check({tag, "_balls"}, 32'(balls_left), 32'd3);
      check({tag, "_text"}, 32'(text_sel), 32'd0);
   endtask

   initial begin
      int cnt;

      // Async reset takes effect before any clock edge.
      #2 reset = 1'b1;
      #1;
      check_idle_outputs("rst");
      check("rst_tick", 32'(refr_tick), 32'd0);
      step();
      step();
      reset = 1'b0;

      // Near-miss pixels must not tick.
      cnt = 0;
      for (int i = 0; i < 6; i++) begin
         pix_x = (i % 2 == 0) ? 10'd0 : 10'd1;
         pix_y = (i % 2 == 0) ? 10'd480 : 10'd481;
         step();
         if (refr_tick) cnt++;
      end
      check("no_tick_near", 32'(cnt), 32'd0);
      pix_x = 10'd0;
      pix_y = 10'd481;
      step();
      check("tick_hi", 32'(refr_tick), 32'd1);
      pix_x = 10'd1;
      step();
      check("tick_lo", 32'(refr_tick), 32'd0);
      pix_x = 10'd5;
      pix_y = 10'd100;

      // Held button gives exactly one reload.
      cnt = 0;
      btn = 2'b01;
      for (int i = 0; i < 10; i++) begin
         step();
         if (ball_reload) cnt++;
         if (i == 0) begin
            check("start_reload", 32'(ball_reload), 32'd1);
            check("start_still", 32'(gra_still), 32'd0);
         end
      end
      btn = 2'b00;
      check("start_reloads", 32'(cnt), 32'd1);
      check("start_text", 32'(text_sel), 32'd1);

      // Twelve separated hits.
      for (int i = 0; i < 12; i++) begin
         hit = 1'b1;
         step();
         hit = 1'b0;
         step();
      end
      check("score12_d1", 32'(dig1), 32'd1);
      check("score12_d0", 32'(dig0), 32'd2);

      // Hit coincident with miss: miss wins.
      hit = 1'b1;
      miss = 1'b1;
      step();
      hit = 1'b0;
      miss = 1'b0;
      check("hm_d1", 32'(dig1), 32'd1);
      check("hm_d0", 32'(dig0), 32'd2);
      check("hm_balls", 32'(balls_left), 32'd2);
      check("hm_text", 32'(text_sel), 32'd2);
      check("hm_still", 32'(gra_still), 32'd1);

      // Early press is ignored and not remembered.
      frame_tick();
      press();
      step();
      check("early_text", 32'(text_sel), 32'd2);
      check("early_reload", 32'(ball_reload), 32'd0);
      frame_tick();
      step();
      step();
      check("expired_wait", 32'(text_sel), 32'd2);
      press();
      check("nb_reload", 32'(ball_reload), 32'd1);
      check("nb_text", 32'(text_sel), 32'd1);
      check("nb_still", 32'(gra_still), 32'd0);
      step();
      check("nb_reload_end", 32'(ball_reload), 32'd0);

      // Second miss and return to play.
      miss = 1'b1;
      step();
      miss = 1'b0;
      check("miss2_balls", 32'(balls_left), 32'd1);
      frame_tick();
      frame_tick();
      press();
      check("play3_text", 32'(text_sel), 32'd1);

      // Final miss enters game over; hits there are ignored.
      miss = 1'b1;
      step();
      miss = 1'b0;
      check("over_text", 32'(text_sel), 32'd3);
      check("over_balls", 32'(balls_left), 32'd0);
      hits(3);
      check("over_hit_d0", 32'(dig0), 32'd2);
      frame_tick();
      step();
      check("over_wait", 32'(text_sel), 32'd3);
      frame_tick();
      step();
      check_idle_outputs("newgame");

      // Score wrap at 99.
      press();
      hits(99);
      check("s99_d1", 32'(dig1), 32'd9);
      check("s99_d0", 32'(dig0), 32'd9);
      hits(1);
      check("wrap_d1", 32'(dig1), 32'd0);
      check("wrap_d0", 32'(dig0), 32'd0);

      // Reset mid-play with score 07, reload in flight.
      hits(7);
      check("s07_d0", 32'(dig0), 32'd7);
      miss = 1'b1;
      step();
      miss = 1'b0;
      frame_tick();
      frame_tick();
      btn = 2'b01;
      @(posedge clk);
      #1;
      check("pre_rst_reload", 32'(ball_reload), 32'd1);
      #2 reset = 1'b1;
      #1;
      check_idle_outputs("midrst");
      btn = 2'b00;
      step();
      reset = 1'b0;
      step();
      check("post_rst_text", 32'(text_sel), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
